shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Sequencer and arbiter that shares one 8-bit logical shift datapath between two requesters, A and B, using a round-robin policy. Each request carries a shift amount of 0-31 and a direction. The shift is applied over multiple clocked passes of at most 7 positions each, so a 0-7 single-pass shifter can serve amounts of 8 and above. It sits between the requesting logic and downstream consumers, with a valid/ready handshake on every side.

Parameters:
WIDTH, 8, data width; this block supports only 8.
AMT_W, 5, width of the shift-amount field (amounts 0-31).
MAX_STEP, 7, maximum shift per datapath pass.

Ports:
clk  input  1  clock; all flops rise-edge.
rst_n  input  1  asynchronous, active-low reset.
a_valid  input  1  requester A has an operation.
a_ready  output  1  A's operation is accepted this cycle.
a_data  input  WIDTH  A operand.
a_amt  input  AMT_W  A shift amount.
a_dir  input  1  A direction: 0 = left, 1 = right. Both are logical shifts with zero fill.
b_valid, b_ready, b_data, b_amt, b_dir  as for A, for requester B.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out_data  output  WIDTH  shifted result.
out_id  output  1  requester of the result: 0 = A, 1 = B.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any time):
  - state = IDLE; a_ready = b_ready = out_valid = busy = 0; out_data = 0; out_id = 0.
  - last_grant = 1, so A wins the first contention.
  - An in-flight operation is discarded; requesters must re-present it.
- States:
  - IDLE: accept at most one request. Grant is combinational.
    - Only one valid: grant it.
    - Both valid: grant the requester that is not last_grant.
    - x_ready = (state == IDLE) and granted_x. Ready is never asserted to a non-valid requester.
  - Accept edge (x_valid and x_ready):
    - Capture acc = x_data, rem = x_amt, dir = x_dir, id = x.
    - Update last_grant = x.
    - Next state is DONE if x_amt == 0, otherwise SHIFT.
  - SHIFT, one pass per cycle:
    - step = min(rem, 7).
    - acc <= shift(acc, step, dir); rem <= rem - step.
    - Next state is DONE when rem - step == 0.
  - DONE:
    - out_valid = 1; out_data = acc and out_id = id, both stable while out_valid is high.
    - On out_valid and out_ready: next state is IDLE.
    - out_valid is held indefinitely under back-pressure.
- Latency: out_valid rises 1 + ceil(amt/7) edges after the accept edge.
  - amt 0: 1 edge. amt 7: 2 edges. amt 8: 3 edges. amt 31: 6 edges.
- Throughput: no request is accepted in SHIFT or DONE. The earliest next accept is the cycle after the output handshake, which is when the FSM is back in IDLE.
- Amounts of 8 or more always yield 0x00, but the full pass count is still executed, so latency follows amount only.
- Requester rules:
  - valid must stay high with data/amt/dir stable until ready.
  - A requester that drops valid before ready loses nothing; the arbiter re-evaluates every IDLE cycle.
- Simultaneous events:
  - A and B both valid in the same IDLE cycle: exactly one ready, chosen per round-robin.
  - A new request arriving in DONE waits; it does not preempt.
- rem is AMT_W bits and never underflows, because step ≤ rem.

Decomposition:
- Shared package holds:
  - constants WIDTH = 8, AMT_W = 5, MAX_STEP = 7;
  - FSM state encoding IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  - requester IDs ID_A = 1'b0, ID_B = 1'b1.
- One combinational sub-module, shift_pass_8, computes one pass:
  - inputs: 8-bit data, 3-bit step, dir;
  - output: 8-bit logical shift with zero fill;
  - built as a 3-stage log shifter, with right shifts done by bit-reversal around a left shifter.
- The controller contains only the FSM, arbiter, and acc/rem/id registers.

Test Plan:
- A only: data 0xAD, amt 3, dir 0 → out_data 0x68, out_id 0, out_valid 2 edges after accept. Then 0xAD, amt 3, dir 1 → 0x15.
- Multi-pass: B only: data 0x80, amt 8, dir 1 → passes of 7 (acc 0x01) then 1 → out_data 0x00, out_id 1, latency 3 edges. Also 0x01, amt 31, dir 0 → 0x00, latency 6.
- Zero amount: A: 0x5A, amt 0, dir 0 → out_data 0x5A, out_valid 1 edge after accept, no SHIFT cycle (busy high exactly 1 cycle when out_ready = 1).
- Contention after reset: A and B valid simultaneously with 0x0F amt 4 dir 0 and 0xF0 amt 4 dir 1 → A served first (0xF0, id 0), then B (0x0F, id 1). Hold both valid continuously → grants alternate A, B, A, B.
- Back-pressure: out_ready = 0 for 5 cycles in DONE → out_valid, out_data and out_id stable; a_ready and b_ready stay 0; completion occurs on the out_ready edge.
- Reset mid-SHIFT: A with amt 20; assert rst_n low during the second pass → out_valid and busy drop to 0 immediately. After release, the FSM is in IDLE and A re-presenting produces the correct result 0x00.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants, state encoding and request type for the shift sequencer.
package shift_seq_ctrl_pkg;

    localparam int WIDTH    = 8;
    localparam int AMT_W    = 5;
    localparam int MAX_STEP = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             dir;
    } req_t;

    // Size of the next pass: whatever is left, capped at one pass of the shifter.
    function automatic logic [2:0] step_of(input logic [AMT_W-1:0] rem);
        return (rem > AMT_W'(MAX_STEP)) ? 3'(MAX_STEP) : rem[2:0];
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester A/B, result and status signals of the shift sequencer.
interface shift_seq_ctrl_if;
    import shift_seq_ctrl_pkg::*;

    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic [AMT_W-1:0] a_amt;
    logic             a_dir;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;
    logic [AMT_W-1:0] b_amt;
    logic             b_dir;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;
    logic             busy;

    // Requesters and consumer side.
    modport master (
        output a_valid, a_data, a_amt, a_dir,
        output b_valid, b_data, b_amt, b_dir,
        output out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_id, busy
    );

    // Sequencer side.
    modport slave (
        input  a_valid, a_data, a_amt, a_dir,
        input  b_valid, b_data, b_amt, b_dir,
        input  out_ready,
        output a_ready, b_ready, out_valid, out_data, out_id, busy
    );

endinterface

// File: rtl/shift_pass_8.sv
// One 0-7 position logical shift pass. Left shift is a 3-stage log shifter;
// right shift reuses it by bit-reversing the operand before and after.
module shift_pass_8
    import shift_seq_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       step,
    input  logic             dir,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] rev_in;
    logic [WIDTH-1:0] rev_out;
    logic [WIDTH-1:0] fwd;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev_in[i]  = data[WIDTH-1-i];
        assign rev_out[i] = s3[WIDTH-1-i];
    end

    assign fwd    = dir ? rev_in : data;
    assign s1     = step[0] ? {fwd[WIDTH-2:0], 1'b0}   : fwd;
    assign s2     = step[1] ? {s1[WIDTH-3:0], 2'b00}   : s1;
    assign s3     = step[2] ? {s2[WIDTH-5:0], 4'b0000} : s2;
    assign result = dir ? rev_out : s3;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Round-robin sequencer sharing one single-pass shifter between requesters A
// and B. Large amounts are applied as repeated passes of at most MAX_STEP.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    shift_seq_ctrl_if.slave   bus
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] rem;
    logic             dir_q;
    logic             id_q;
    logic             last_grant;

    logic             gnt_a;
    logic             gnt_b;
    logic             accept;
    req_t             req_sel;
    logic [2:0]       step;
    logic [AMT_W-1:0] rem_nxt;
    logic [WIDTH-1:0] acc_shift;

    // Arbitration: a lone valid wins, on contention the one not served last wins.
    always_comb begin
        gnt_a  = bus.a_valid && (!bus.b_valid || (last_grant == ID_B));
        gnt_b  = bus.b_valid && (!bus.a_valid || (last_grant == ID_A));
        accept = (state == IDLE) && (gnt_a || gnt_b);
        if (gnt_b) begin
            req_sel.data = bus.b_data;
            req_sel.amt  = bus.b_amt;
            req_sel.dir  = bus.b_dir;
        end else begin
            req_sel.data = bus.a_data;
            req_sel.amt  = bus.a_amt;
            req_sel.dir  = bus.a_dir;
        end
    end

    assign step    = step_of(rem);
    assign rem_nxt = rem - AMT_W'(step);

    shift_pass_8 u_pass (
        .data   (acc),
        .step   (step),
        .dir    (dir_q),
        .result (acc_shift)
    );

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: zero amount skips SHIFT, last pass goes to DONE, DONE waits for consumer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = (req_sel.amt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (rem_nxt == '0) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: readies only in IDLE, result held straight from the registers.
    always_comb begin
        bus.a_ready   = (state == IDLE) && gnt_a;
        bus.b_ready   = (state == IDLE) && gnt_b;
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_data  = acc;
        bus.out_id    = id_q;
    end

    // Operand capture on accept, then one pass per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            rem        <= '0;
            dir_q      <= 1'b0;
            id_q       <= ID_A;
            last_grant <= ID_B;
        end else if (accept) begin
            acc        <= req_sel.data;
            rem        <= req_sel.amt;
            dir_q      <= req_sel.dir;
            id_q       <= gnt_b ? ID_B : ID_A;
            last_grant <= gnt_b ? ID_B : ID_A;
        end else if (state == SHIFT) begin
            acc <= acc_shift;
            rem <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: directed table, round-robin, back-pressure and
// reset corner cases, then random operations against an arithmetic model.
module tb_shift_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    shift_seq_ctrl_if bus ();

    shift_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         who;
        logic [7:0] d;
        logic [4:0] amt;
        bit         dir;
        logic [7:0] exp;
        int         bp;
    } vec_t;

    vec_t tbl[9];

    // Logical shift with zero fill; anything 8 or more clears the byte.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [4:0] amt, input bit dir);
        logic [15:0] t;
        if (amt >= 8) return 8'h00;
        t = {8'h00, d};
        t = dir ? (t >> amt) : (t << amt);
        return t[7:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.a_data = 0; bus.a_amt = 0; bus.a_dir = 0;
        bus.b_valid = 0; bus.b_data = 0; bus.b_amt = 0; bus.b_dir = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        #1;
        check("rst busy", bus.busy, 0);
        check("rst out_valid", bus.out_valid, 0);
        check("rst out_data", bus.out_data, 0);
        check("rst out_id", bus.out_id, 0);
        check("rst a_ready", bus.a_ready, 0);
        check("rst b_ready", bus.b_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // One operation from a single requester, optionally with bp cycles of back-pressure.
    task automatic op(input bit who, input logic [7:0] d, input logic [4:0] amt, input bit dir,
                      input logic [7:0] exp, input int bp, input string nm);
        int lat, exp_lat, w;
        exp_lat = 1 + (int'(amt) + 6) / 7;
        @(negedge clk);
        if (!who) begin bus.a_valid = 1; bus.a_data = d; bus.a_amt = amt; bus.a_dir = dir; end
        else      begin bus.b_valid = 1; bus.b_data = d; bus.b_amt = amt; bus.b_dir = dir; end
        #1;
        w = 0;
        while (!(who ? bus.b_ready : bus.a_ready) && w < 20) begin @(negedge clk); #1; w++; end
        if (w >= 20) begin fail_now({nm, " ready"}); idle_inputs(); return; end
        check({nm, " other_ready"}, who ? bus.a_ready : bus.b_ready, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        if (bp > 0) bus.out_ready = 0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!bus.out_valid) begin fail_now({nm, " out_valid"}); bus.out_ready = 1; return; end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " data"}, bus.out_data, exp);
        check({nm, " id"}, bus.out_id, who);
        for (int i = 0; i < bp; i++) begin
            bus.a_valid = 1; bus.a_data = 8'h33; bus.a_amt = 5'd1;
            bus.b_valid = 1; bus.b_data = 8'hCC; bus.b_amt = 5'd2;
            #1;
            check({nm, " bp a_ready"}, bus.a_ready, 0);
            check({nm, " bp b_ready"}, bus.b_ready, 0);
            check({nm, " bp valid"}, bus.out_valid, 1);
            check({nm, " bp data"}, bus.out_data, exp);
            check({nm, " bp id"}, bus.out_id, who);
            @(negedge clk);
        end
        idle_inputs();
        bus.out_ready = 1;
        @(negedge clk);
        check({nm, " post busy"}, bus.busy, 0);
        check({nm, " post valid"}, bus.out_valid, 0);
    endtask

    initial begin
        int w;
        bit winner;
        bit rw;
        logic [7:0] rd;
        logic [4:0] ra;
        bit rdir;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bit winner;
        bit rw;
        logic [7:0] rd;
        logic [4:0] ra;
        bit rdir;

        tbl[0] = '{0, 8'hAD, 5'd3,  0, 8'h68, 0};
        tbl[1] = '{0, 8'hAD, 5'd3,  1, 8'h15, 0};
        tbl[2] = '{1, 8'h80, 5'd8,  1, 8'h00, 0};
        tbl[3] = '{1, 8'h01, 5'd31, 0, 8'h00, 0};
        tbl[4] = '{0, 8'h5A, 5'd0,  0, 8'h5A, 0};
        tbl[5] = '{1, 8'h81, 5'd7,  1, 8'h01, 0};
        tbl[6] = '{0, 8'h81, 5'd7,  0, 8'h80, 0};
        tbl[7] = '{1, 8'hFF, 5'd1,  0, 8'hFE, 0};
        tbl[8] = '{0, 8'hC3, 5'd2,  1, 8'h30, 5};

        idle_inputs();
        bus.out_ready = 1;
        do_reset();

        // Contention straight out of reset: A first, then strict alternation.
        @(negedge clk);
        bus.a_valid = 1; bus.a_data = 8'h0F; bus.a_amt = 5'd4; bus.a_dir = 0;
        bus.b_valid = 1; bus.b_data = 8'hF0; bus.b_amt = 5'd4; bus.b_dir = 1;
        #1;
        for (int g = 0; g < 4; g++) begin
            w = 0;
            while (!(bus.a_ready || bus.b_ready) && w < 20) begin @(negedge clk); #1; w++; end
            if (w >= 20) begin fail_now("rr grant"); break; end
            check($sformatf("rr onehot %0d", g), {31'd0, bus.a_ready} + {31'd0, bus.b_ready}, 1);
            winner = bus.b_ready;
            check($sformatf("rr order %0d", g), winner, g % 2);
            w = 0;
            while (!bus.out_valid && w < 20) begin @(negedge clk); #1; w++; end
            if (w >= 20) begin fail_now("rr result"); break; end
            check($sformatf("rr data %0d", g), bus.out_data, winner ? 8'h0F : 8'hF0);
            check($sformatf("rr id %0d", g), bus.out_id, winner);
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);

        foreach (tbl[i])
            op(tbl[i].who, tbl[i].d, tbl[i].amt, tbl[i].dir, tbl[i].exp, tbl[i].bp,
               $sformatf("vec%0d", i));

        // Reset during the second pass of a 20-position shift.
        @(negedge clk);
        bus.a_valid = 1; bus.a_data = 8'hC3; bus.a_amt = 5'd20; bus.a_dir = 1;
        #1;
        w = 0;
        while (!bus.a_ready && w < 20) begin @(negedge clk); #1; w++; end
        if (w >= 20) fail_now("midrst ready");
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #2;
        check("midrst busy before", bus.busy, 1);
        rst_n = 0;
        #1;
        check("midrst busy", bus.busy, 0);
        check("midrst out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("midrst idle", bus.busy, 0);
        op(0, 8'hC3, 5'd20, 1, 8'h00, 0, "midrst redo");

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            rd   = 8'($urandom_range(0, 255));
            ra   = 5'($urandom_range(0, 31));
            rdir = 1'($urandom_range(0, 1));
            op(rw, rd, ra, rdir, model(rd, ra, rdir), $urandom_range(0, 2),
               $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
